// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Purpose:
//   Display stage of the stopwatch. Scans the four digit codes (SS0, SS1,
//   MM0, MM1) onto a common-anode 4-digit seven-segment display.
//   - Digits are snapshotted into shadow registers at each frame boundary,
//     so the display never tears.
//   - Each digit slot begins with a short all-off dead-time to avoid ghosting.
//   - The MM0 decimal point acts as a colon that blinks at a frame-based rate.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, the MM1 slot stays dark if the snapshotted MM1 digit is 0.
//
// Parameters:
//   DIV          clk cycles per digit slot (>= 2)
//   BLANK_CYCLES dead-time cycles at the start of each slot (0..DIV-1)
//   BLINK_FRAMES scan frames per half-period of the colon blink (>= 1)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   SS0..MM1   in   4-bit digit codes (seconds units/tens, minutes units/tens)
//   colon_en   in   enables the blinking colon; sampled every cycle
//   an         out  digit anodes, active-low; an[0]=SS0 .. an[3]=MM1
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low; used only in the MM0 slot
//   frame_tick out  one-cycle pulse following each frame boundary
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
   parameter int DIV          = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] SS0,
   input  logic [3:0] SS1,
   input  logic [3:0] MM0,
   input  logic [3:0] MM1,
   input  logic       colon_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int CNT_W  = $clog2(DIV);
   localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYCLES);
   localparam logic [BCNT_W-1:0] LAST_BCNT = BCNT_W'(BLINK_FRAMES - 1);

   // Active-low {g,f,e,d,c,b,a}; codes 10..15 show a dash as an error mark.
   function automatic logic [6:0] f_decode(input logic [3:0] i_d);
      logic [6:0] v;
      case (i_d)
         4'd0:    v = 7'h40;
         4'd1:    v = 7'h79;
         4'd2:    v = 7'h24;
         4'd3:    v = 7'h30;
         4'd4:    v = 7'h19;
         4'd5:    v = 7'h12;
         4'd6:    v = 7'h02;
         4'd7:    v = 7'h78;
         4'd8:    v = 7'h00;
         4'd9:    v = 7'h10;
         default: v = 7'h3F;
      endcase
      return v;
   endfunction

   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_idx;
   logic [3:0]        r_sh [4];
   logic [BCNT_W-1:0] r_bcnt;
   logic              r_bph;

   logic              w_slot_end;
   logic              w_frame_end;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [1:0]        w_idx_nxt;
   logic [3:0]        w_digit_nxt;
   logic              w_bph_nxt;
   logic              w_dead_nxt;
   logic              w_lz_blank;
   logic              w_off;

   // Outputs are registered from the next-state scan position, so the
   // registered an/seg/dp always match the (cnt, idx) held in the same cycle.
   always_comb begin
      w_slot_end  = (r_cnt == LAST_CNT);
      w_frame_end = w_slot_end && (r_idx == 2'd3);
      w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
      w_idx_nxt   = w_slot_end ? r_idx + 2'd1 : r_idx;
      // At a frame boundary the next slot is SS0, taken straight from the
      // input that is being snapshotted on this same edge.
      w_digit_nxt = w_frame_end ? SS0 : r_sh[w_idx_nxt];
      w_bph_nxt   = (w_frame_end && (r_bcnt == LAST_BCNT)) ? ~r_bph : r_bph;
      w_dead_nxt  = (w_cnt_nxt < BLANK_LIM);
`ifdef LEADING_ZERO_BLANK_EN
      w_lz_blank  = (w_idx_nxt == 2'd3) && (w_digit_nxt == 4'd0);
`else
      w_lz_blank  = 1'b0;
`endif
      w_off       = w_dead_nxt || w_lz_blank;
   end

   // Scan position, shadow digits and blink state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_idx  <= 2'd0;
         for (int i = 0; i < 4; i++) r_sh[i] <= 4'd0;
         r_bcnt <= '0;
         r_bph  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_idx <= w_idx_nxt;
         if (w_frame_end) begin
            r_sh[0] <= SS0;
            r_sh[1] <= SS1;
            r_sh[2] <= MM0;
            r_sh[3] <= MM1;
            r_bcnt  <= (r_bcnt == LAST_BCNT) ? '0 : r_bcnt + 1'b1;
            r_bph   <= w_bph_nxt;
         end
      end
   end

   // Registered display outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an         <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= w_off ? 4'hF : ~(4'b0001 << w_idx_nxt);
         seg        <= w_off ? 7'h7F : f_decode(w_digit_nxt);
         dp         <= ~(!w_dead_nxt && (w_idx_nxt == 2'd2) && colon_en && w_bph_nxt);
         frame_tick <= w_frame_end;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] SS0, SS1, MM0, MM1;
   logic       colon_en;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   int n_total = 0;
   int n_bad   = 0;

   seven_seg_scan_driver #(.DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)) dut (
      .clk(clk), .reset(reset),
      .SS0(SS0), .SS1(SS1), .MM0(MM0), .MM1(MM1),
      .colon_en(colon_en),
      .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts on a frame_tick cycle (cnt=0, idx=0) and checks 16 cycles,
   // ending on the next frame_tick cycle.
   task automatic run_frame(input int fr, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] an3, input logic lit);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      for (int i = 0; i < 16; i++) begin
         int sl = i / 4;
         int c  = i % 4;
         if (c == 0) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         end else begin
            case (sl)
               0: begin e_an = 4'hE; e_seg = s0; end
               1: begin e_an = 4'hD; e_seg = s1; end
               2: begin e_an = 4'hB; e_seg = s2; end
               default: begin e_an = an3; e_seg = s3; end
            endcase
            e_dp = (sl == 2 && lit) ? 1'b0 : 1'b1;
         end
         check($sformatf("f%0d_c%0d_tick", fr, i), 32'(frame_tick), 32'(i == 0));
         check($sformatf("f%0d_c%0d_an", fr, i), 32'(an), 32'(e_an));
         check($sformatf("f%0d_c%0d_seg", fr, i), 32'(seg), 32'(e_seg));
         check($sformatf("f%0d_c%0d_dp", fr, i), 32'(dp), 32'(e_dp));
         step();
      end
   endtask

   task automatic wait_tick(input string tag);
      logic got = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (!got) begin
            step();
            if (frame_tick) got = 1'b1;
         end
      end
      check(tag, 32'(got), 32'd1);
   endtask

   logic [6:0] seg_mm1_zero;
   logic [3:0] an_mm1_zero;

   initial begin
`ifdef LEADING_ZERO_BLANK_EN
      seg_mm1_zero = 7'h7F; an_mm1_zero = 4'hF;
`else
      seg_mm1_zero = 7'h40; an_mm1_zero = 4'h7;
`endif
      reset = 1'b1; colon_en = 1'b0;
      SS0 = 4'd5; SS1 = 4'd3; MM0 = 4'd2; MM1 = 4'd1;
      repeat (3) step();
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
      check("rst_tick", 32'(frame_tick), 32'd0);

      @(negedge clk); reset = 1'b0;
      step(); step();                      // cnt=2, idx=0, shadow still zero
      check("pre_an", 32'(an), 32'hE);
      check("pre_seg", 32'(seg), 32'h40);
      check("pre_tick", 32'(frame_tick), 32'd0);
      wait_tick("tick1_seen");

      // Frame 1: bph=0, colon off
      run_frame(1, 7'h12, 7'h30, 7'h24, 7'h79, 4'h7, 1'b0);

      // Frame 2: bph=1, colon on; SS0/SS1 change in the SS1 slot must not tear
      colon_en = 1'b1;
      fork
         run_frame(2, 7'h12, 7'h30, 7'h24, 7'h79, 4'h7, 1'b1);
         begin
            repeat (6) @(negedge clk);
            SS0 = 4'd9; SS1 = 4'd8;
         end
      join

      // Frame 3: bph=1, new digits visible; MM0 error code queued
      MM0 = 4'hB;
      run_frame(3, 7'h10, 7'h00, 7'h24, 7'h79, 4'h7, 1'b1);

      // Frame 4: bph=0, dash on MM0
      MM1 = 4'd0;
      run_frame(4, 7'h10, 7'h00, 7'h3F, 7'h79, 4'h7, 1'b0);

      // Frame 5: bph=0, leading zero now in shadow
      run_frame(5, 7'h10, 7'h00, 7'h3F, seg_mm1_zero, an_mm1_zero, 1'b0);

      // Frame 6: bph=1 but colon disabled
      colon_en = 1'b0;
      run_frame(6, 7'h10, 7'h00, 7'h3F, seg_mm1_zero, an_mm1_zero, 1'b0);

      // Frame 7: bph=1, colon re-enabled (not snapshotted)
      colon_en = 1'b1;
      run_frame(7, 7'h10, 7'h00, 7'h3F, seg_mm1_zero, an_mm1_zero, 1'b1);

      // Mid-frame reset at idx=2, cnt=2
      repeat (10) step();
      check("mid_an_pre", 32'(an), 32'hB);
      reset = 1'b1;
      #1;
      check("mid_rst_an", 32'(an), 32'hF);
      check("mid_rst_seg", 32'(seg), 32'h7F);
      check("mid_rst_dp", 32'(dp), 32'd1);
      check("mid_rst_tick", 32'(frame_tick), 32'd0);
      step();
      @(negedge clk); reset = 1'b0;
      step(); step();                      // cnt=2, idx=0
      check("post_an", 32'(an), 32'hE);
      check("post_seg", 32'(seg), 32'h40);
      repeat (7) step();                   // cnt=1, idx=2; bph back to 0
      check("post_mm0_an", 32'(an), 32'hB);
      check("post_mm0_seg", 32'(seg), 32'h40);
      check("post_mm0_dp", 32'(dp), 32'd1);
      wait_tick("tick_after_reset");
      run_frame(8, 7'h10, 7'h00, 7'h3F, seg_mm1_zero, an_mm1_zero, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
